// File: rtl/int_gen_pkg.sv
// int_gen_pkg: shared definitions for the external-interrupt source.
//   state_e       FSM states (IDLE, ASSERT, DRAIN)
//   ACK_ADDR_DEF  default interrupt-acknowledge word address
//   TIMEOUT_DEF   default maximum interrupt hold time in cycles
//   MIN_GAP_DEF   default low time after an ack in cycles
//   is_ack()      decodes a CPU store to the acknowledge word
package int_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   localparam logic [31:0] ACK_ADDR_DEF = 32'h0000_7F20;
   localparam int          TIMEOUT_DEF  = 1024;
   localparam int          MIN_GAP_DEF  = 4;

   // A store with any byte lane enabled to the acknowledge word; the two
   // byte-offset bits are masked so sub-word stores also acknowledge.
   function automatic logic is_ack(input logic [31:0] addr,
                                   input logic [3:0]  byteen,
                                   input logic [31:0] ack_addr);
      return ((addr & 32'hFFFF_FFFC) == (ack_addr & 32'hFFFF_FFFC)) &&
             (byteen != 4'b0000);
   endfunction

endpackage

// File: rtl/int_gen_if.sv
// int_gen_if: CPU-side bus between the mips core and int_gen.
//   macroscopic_pc  CPU macroscopic PC
//   m_data_addr     CPU data address
//   m_data_byteen   CPU store byte enables
//   interrupt       external interrupt into the CPU
// master = CPU (or bench) side, slave = int_gen side.
interface int_gen_if;
   logic [31:0] macroscopic_pc;
   logic [31:0] m_data_addr;
   logic [3:0]  m_data_byteen;
   logic        interrupt;

   modport master (output macroscopic_pc, output m_data_addr,
                   output m_data_byteen, input interrupt);
   modport slave  (input macroscopic_pc, input m_data_addr,
                   input m_data_byteen, output interrupt);
endinterface

// File: rtl/int_trig_slot.sv
// int_trig_slot: one one-shot trigger slot.
//   clk, reset_n  clock and asynchronous active-low reset
//   wr_en, wr_pc  configuration write to this slot (loads PC and arms)
//   cur_pc        CPU macroscopic PC to compare against
//   clr           disarm request, honoured only for a slot that hit
//   hit           slot armed, PC equal, and not being rewritten this cycle
module int_trig_slot (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic [31:0] cur_pc,
   input  logic        clr,
   output logic        hit
);

   logic        armed_r;
   logic [31:0] pc_r;

   // A write in the same cycle suppresses the hit: the new PC wins.
   assign hit = armed_r && (cur_pc == pc_r) && !wr_en;

   // Slot PC and armed flag; write has priority over disarm.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_r <= 1'b0;
         pc_r    <= 32'h0000_0000;
      end else if (wr_en) begin
         armed_r <= 1'b1;
         pc_r    <= wr_pc;
      end else if (clr && hit) begin
         armed_r <= 1'b0;
      end else begin
         armed_r <= armed_r;
      end
   end

endmodule

// File: rtl/int_gen.sv
// int_gen: external interrupt source for the mips exception test bench.
//   clk, reset_n           clock and asynchronous active-low reset
//   cfg_we/cfg_idx/cfg_pc  program and arm a trigger slot
//   bus                    CPU-side bus (PC, store address/byte enables, interrupt)
//   busy                   FSM not idle
//   fired_cnt              interrupts raised, saturating at 255
//   err_timeout            sticky: interrupt held TIMEOUT cycles without an ack
//   err_spurious           sticky: ack seen outside ASSERT
module int_gen
   import int_gen_pkg::*;
#(
   parameter int          NUM_TRIG = 4,
   parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEF,
   parameter int          TIMEOUT  = TIMEOUT_DEF,
   parameter int          MIN_GAP  = MIN_GAP_DEF,
   localparam int         IDX_W    = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [31:0]      cfg_pc,
   int_gen_if.slave         bus,
   output logic             busy,
   output logic [7:0]       fired_cnt,
   output logic             err_timeout,
   output logic             err_spurious
);

   localparam int HOLD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_GAP - 1);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_ASSERT = ST_ASSERT;
   localparam logic [1:0] S_DRAIN  = ST_DRAIN;

   logic [1:0]          state_r;
   logic [1:0]          state_nxt_s;
   logic                interrupt_r;
   logic                busy_r;
   logic [7:0]          fired_r;
   logic                err_to_r;
   logic                err_sp_r;
   logic [HOLD_W-1:0]   hold_r;
   logic [GAP_W-1:0]    gap_r;
   logic [NUM_TRIG-1:0] hit_s;
   logic                ack_s;
   logic                fire_s;
   logic                set_to_s;
   logic                set_sp_s;

   assign ack_s  = is_ack(bus.m_data_addr, bus.m_data_byteen, ACK_ADDR);
   assign fire_s = (state_r == S_IDLE) && (|hit_s);

   for (genvar k = 0; k < NUM_TRIG; k++) begin : g_slot
      int_trig_slot u_slot (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_en   (cfg_we && (cfg_idx == IDX_W'(k))),
         .wr_pc   (cfg_pc),
         .cur_pc  (bus.macroscopic_pc),
         .clr     (fire_s),
         .hit     (hit_s[k])
      );
   end

   // Next-state and error-flag decode.
   always_comb begin
      state_nxt_s = state_r;
      set_to_s    = 1'b0;
      set_sp_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            set_sp_s = ack_s;
            if (fire_s) begin
               state_nxt_s = S_ASSERT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_ASSERT: begin
            // An ack in the last hold cycle still counts as a clean ack.
            if (ack_s) begin
               state_nxt_s = (MIN_GAP > 1) ? S_DRAIN : S_IDLE;
            end else if (hold_r == HOLD_LAST) begin
               state_nxt_s = S_IDLE;
               set_to_s    = 1'b1;
            end else begin
               state_nxt_s = S_ASSERT;
            end
         end
         S_DRAIN: begin
            set_sp_s = ack_s;
            if (gap_r == GAP_LAST) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DRAIN;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register with interrupt and busy registered alongside it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= S_IDLE;
         interrupt_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         interrupt_r <= (state_nxt_s == S_ASSERT);
         busy_r      <= (state_nxt_s != S_IDLE);
      end
   end

   // Hold counter: zero in the first ASSERT cycle, +1 per ASSERT cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_r <= '0;
      end else if (state_r == S_ASSERT) begin
         hold_r <= hold_r + HOLD_W'(1);
      end else begin
         hold_r <= '0;
      end
   end

   // Gap counter starts at 1 on DRAIN entry: the IDLE cycle that follows
   // DRAIN is the last low cycle, giving MIN_GAP low cycles in total.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_r <= GAP_W'(1);
      end else if (state_r == S_DRAIN) begin
         gap_r <= gap_r + GAP_W'(1);
      end else begin
         gap_r <= GAP_W'(1);
      end
   end

   // Saturating fire counter and sticky error flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fired_r  <= 8'd0;
         err_to_r <= 1'b0;
         err_sp_r <= 1'b0;
      end else begin
         if (fire_s && (fired_r != 8'hFF)) begin
            fired_r <= fired_r + 8'd1;
         end else begin
            fired_r <= fired_r;
         end
         err_to_r <= err_to_r | set_to_s;
         err_sp_r <= err_sp_r | set_sp_s;
      end
   end

   assign bus.interrupt = interrupt_r;
   assign busy          = busy_r;
   assign fired_cnt     = fired_r;
   assign err_timeout   = err_to_r;
   assign err_spurious  = err_sp_r;

endmodule

// File: tb/tb_int_gen.sv
// tb_int_gen: randomized and directed self-checking bench for int_gen with a
// behavioural reference model of the interrupt protocol.
module tb_int_gen;
   localparam int NT = 4;
   localparam int TO = 1024;
   localparam int MG = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = 2'd0;
   logic [31:0] cfg_pc = 32'h0;
   logic        busy;
   logic [7:0]  fired_cnt;
   logic        err_timeout;
   logic        err_spurious;

   int_gen_if bus();

   int_gen #(.NUM_TRIG(NT), .ACK_ADDR(32'h0000_7F20), .TIMEOUT(TO), .MIN_GAP(MG)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_pc       (cfg_pc),
      .bus          (bus),
      .busy         (busy),
      .fired_cnt    (fired_cnt),
      .err_timeout  (err_timeout),
      .err_spurious (err_spurious)
   );

   always #5 clk = ~clk;

   // Reference model: interrupt level, cycles held, low cycles still owed
   // after an ack, counters, flags and slot contents.
   bit          m_irq;
   int          m_hold;
   int          m_quiet;
   int          m_cnt;
   bit          m_to;
   bit          m_sp;
   bit          m_armed [NT];
   logic [31:0] m_pc    [NT];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_irq = 0; m_hold = 0; m_quiet = 0; m_cnt = 0; m_to = 0; m_sp = 0;
      for (int k = 0; k < NT; k++) begin
         m_armed[k] = 0;
         m_pc[k]    = 32'h0;
      end
   endtask

   task automatic model_edge();
      bit ack;
      bit hit [NT];
      bit any;
      ack = (bus.m_data_addr[31:2] == 30'h0000_1FC8) && (bus.m_data_byteen != 4'b0000);
      any = 0;
      for (int k = 0; k < NT; k++) begin
         hit[k] = m_armed[k] && (bus.macroscopic_pc == m_pc[k]) &&
                  !(cfg_we && (int'(cfg_idx) == k));
         any |= hit[k];
      end
      if (m_irq) begin
         if (ack) begin
            m_irq = 0; m_quiet = MG - 1;
         end else if (m_hold == TO - 1) begin
            m_irq = 0; m_to = 1; m_quiet = 0;
         end else begin
            m_hold++;
         end
      end else if (m_quiet > 0) begin
         if (ack) m_sp = 1;
         m_quiet--;
      end else begin
         if (ack) m_sp = 1;
         if (any) begin
            for (int k = 0; k < NT; k++) if (hit[k]) m_armed[k] = 0;
            if (m_cnt < 255) m_cnt++;
            m_irq = 1; m_hold = 0;
         end
      end
      if (cfg_we) begin
         m_armed[cfg_idx] = 1;
         m_pc[cfg_idx]    = cfg_pc;
      end
   endtask

   task automatic compare_all();
      chk("interrupt", 32'(bus.interrupt), 32'(m_irq));
      chk("busy", 32'(busy), 32'(m_irq || (m_quiet > 0)));
      chk("fired_cnt", 32'(fired_cnt), 32'(m_cnt));
      chk("err_timeout", 32'(err_timeout), 32'(m_to));
      chk("err_spurious", 32'(err_spurious), 32'(m_sp));
   endtask

   // One clock: advance the model on the edge, then check every output.
   task automatic step();
      @(posedge clk);
      if (reset_n) model_edge();
      else model_reset();
      #1;
      compare_all();
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [31:0] pc);
      cfg_we = 1'b1; cfg_idx = idx; cfg_pc = pc;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic ack_pulse(input logic [3:0] be);
      bus.m_data_addr = 32'h0000_7F20; bus.m_data_byteen = be;
      step();
      bus.m_data_addr = 32'h0; bus.m_data_byteen = 4'b0000;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.macroscopic_pc = 32'h0; bus.m_data_addr = 32'h0; bus.m_data_byteen = 4'b0000;
      model_reset();
      #2;
      chk("rst_irq", 32'(bus.interrupt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(fired_cnt), 32'd0);
      step(); step();
      reset_n = 1'b1;
      step();

      // Walk the PC up to the trigger.
      bus.macroscopic_pc = 32'h3000;
      cfg_write(2'd0, 32'h3010);
      for (int a = 32'h3004; a <= 32'h3010; a += 4) begin
         bus.macroscopic_pc = 32'(a);
         step();
         chk("walk_irq", 32'(bus.interrupt), 32'(a == 32'h3010));
      end
      chk("walk_cnt", 32'(fired_cnt), 32'd1);

      // Ack with slot1 already matching: exactly MIN_GAP low cycles.
      bus.macroscopic_pc = 32'h3020;
      cfg_write(2'd1, 32'h3020);
      step(); step();
      ack_pulse(4'b1111);
      chk("ack_low", 32'(bus.interrupt), 32'd0);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.interrupt) break;
         n++;
      end
      chk("gap_low_cycles", 32'(n), 32'd4);
      chk("refire_cnt", 32'(fired_cnt), 32'd2);

      // No ack: times out after TIMEOUT high cycles.
      n = 1;
      for (int i = 0; i < 1100; i++) begin
         step();
         if (!bus.interrupt) break;
         n++;
      end
      chk("hold_cycles", 32'(n), 32'd1024);
      chk("timeout_flag", 32'(err_timeout), 32'd1);
      step(); step();
      chk("timeout_sticky", 32'(err_timeout), 32'd1);

      // Spurious-ack decode.
      bus.m_data_addr = 32'h0000_7F24; bus.m_data_byteen = 4'b1111;
      step();
      chk("near_addr_sp", 32'(err_spurious), 32'd0);
      ack_pulse(4'b0000);
      chk("no_byteen_sp", 32'(err_spurious), 32'd0);
      ack_pulse(4'b0001);
      chk("spurious", 32'(err_spurious), 32'd1);
      chk("spurious_irq", 32'(bus.interrupt), 32'd0);

      // Two slots on the same PC: one fire, both disarmed.
      bus.macroscopic_pc = 32'h3000;
      cfg_write(2'd0, 32'h3008);
      cfg_write(2'd2, 32'h3008);
      bus.macroscopic_pc = 32'h3008;
      step();
      chk("dual_cnt", 32'(fired_cnt), 32'd3);
      ack_pulse(4'b1111);
      for (int i = 0; i < 6; i++) step();
      chk("dual_disarmed", 32'(fired_cnt), 32'd3);

      // Write to slot0 in its match cycle: slot2 fires, slot0 stays armed.
      bus.macroscopic_pc = 32'h3000;
      cfg_write(2'd2, 32'h3008);
      bus.macroscopic_pc = 32'h3008;
      cfg_write(2'd0, 32'h3008);
      chk("wr_win_cnt", 32'(fired_cnt), 32'd4);
      ack_pulse(4'b1111);
      for (int i = 0; i < 5; i++) step();
      chk("slot0_kept", 32'(fired_cnt), 32'd5);
      ack_pulse(4'b1111);
      for (int i = 0; i < 5; i++) step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int r;
         cfg_we  = ($urandom_range(0, 7) == 0);
         cfg_idx = 2'($urandom_range(0, 3));
         cfg_pc  = 32'h3000 + 32'(4 * $urandom_range(0, 7));
         bus.macroscopic_pc = 32'h3000 + 32'(4 * $urandom_range(0, 7));
         r = $urandom_range(0, 9);
         bus.m_data_addr = (r == 0) ? 32'h0000_7F20 :
                           (r == 1) ? 32'h0000_7F24 : 32'h0000_1000 + 32'($urandom_range(0, 255));
         bus.m_data_byteen = 4'($urandom_range(0, 15));
         step();
      end
      cfg_we = 1'b0; bus.m_data_addr = 32'h0; bus.m_data_byteen = 4'b0000;
      for (int i = 0; i < 8; i++) step();
      if (bus.interrupt) ack_pulse(4'b1111);
      for (int i = 0; i < 6; i++) step();

      // Drive fired_cnt into saturation.
      bus.macroscopic_pc = 32'h3000;
      for (int i = 0; i < 300; i++) begin
         cfg_write(2'd0, 32'h3000);
         for (int j = 0; j < 10; j++) begin
            if (bus.interrupt) break;
            step();
         end
         ack_pulse(4'b1111);
      end
      chk("saturate", 32'(fired_cnt), 32'd255);
      for (int i = 0; i < 6; i++) step();

      // Reset in the middle of ASSERT.
      bus.macroscopic_pc = 32'h3040;
      cfg_write(2'd1, 32'h3040);
      step();
      chk("pre_reset_irq", 32'(bus.interrupt), 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("async_irq", 32'(bus.interrupt), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_cnt", 32'(fired_cnt), 32'd0);
      chk("async_err", 32'({err_timeout, err_spurious}), 32'd0);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("no_fire_after_rst", 32'(bus.interrupt), 32'd0);
      cfg_write(2'd1, 32'h3040);
      step();
      chk("reprogram_fire", 32'(bus.interrupt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
